// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: datapath defaults, ALU op codes and
// the arbiter FSM state type.
package alu_share_arbiter_pkg;

  localparam int unsigned Width = 32;
  localparam int unsigned OpW   = 4;
  localparam int unsigned ShW   = 5;

  localparam logic [OpW-1:0] AluAnd = 4'b0000;
  localparam logic [OpW-1:0] AluOr  = 4'b0001;
  localparam logic [OpW-1:0] AluAdd = 4'b0010;
  localparam logic [OpW-1:0] AluNor = 4'b0011;
  localparam logic [OpW-1:0] AluSll = 4'b0100;
  localparam logic [OpW-1:0] AluSrl = 4'b0101;
  localparam logic [OpW-1:0] AluSub = 4'b0110;
  localparam logic [OpW-1:0] AluSlt = 4'b0111;
  localparam logic [OpW-1:0] AluSra = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters; shifts act on x by shamt,
// compare is a signed set-less-than, undefined op codes yield zero.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned Width = alu_share_arbiter_pkg::Width,
  parameter int unsigned OpW   = alu_share_arbiter_pkg::OpW,
  parameter int unsigned ShW   = alu_share_arbiter_pkg::ShW
) (
  input  logic [OpW-1:0]   op_i,
  input  logic [Width-1:0] x_i,
  input  logic [Width-1:0] y_i,
  input  logic [ShW-1:0]   shamt_i,
  output logic [Width-1:0] result_o,
  output logic             zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      AluAnd:  result_o = x_i & y_i;
      AluOr:   result_o = x_i | y_i;
      AluAdd:  result_o = x_i + y_i;
      AluNor:  result_o = ~(x_i | y_i);
      AluSll:  result_o = x_i << shamt_i;
      AluSrl:  result_o = x_i >> shamt_i;
      AluSub:  result_o = x_i - y_i;
      AluSlt:  result_o = {{(Width-1){1'b0}}, ($signed(x_i) < $signed(y_i))};
      AluSra:  result_o = Width'($signed(x_i) >>> shamt_i);
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters; operands and
// result are registered and only one operation is in flight at a time.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned Width = alu_share_arbiter_pkg::Width,
  parameter int unsigned OpW   = alu_share_arbiter_pkg::OpW,
  parameter int unsigned ShW   = alu_share_arbiter_pkg::ShW,
  parameter int unsigned CntW  = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [2*OpW-1:0]   req_op_i,
  input  logic [2*Width-1:0] req_x_i,
  input  logic [2*Width-1:0] req_y_i,
  input  logic [2*ShW-1:0]   req_shamt_i,
  output logic [1:0]         resp_valid_o,
  input  logic [1:0]         resp_ready_i,
  output logic [Width-1:0]   resp_result_o,
  output logic               resp_zero_o,
  output logic               busy_o,
  output logic [CntW-1:0]    op_count_o
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_last_q, rr_last_d;
  logic [OpW-1:0]     op_q, op_d;
  logic [Width-1:0]   x_q, x_d;
  logic [Width-1:0]   y_q, y_d;
  logic [ShW-1:0]     shamt_q, shamt_d;
  logic [Width-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               grant;
  logic [Width-1:0]   alu_result;
  logic               alu_zero;

  // Ties go to the requester that did not win last; otherwise the sole valid one.
  always_comb begin
    if (&req_valid_i) begin
      grant = ~rr_last_q;
    end else begin
      grant = req_valid_i[1];
    end
  end

  alu_share_arbiter_alu #(
    .Width (Width),
    .OpW   (OpW),
    .ShW   (ShW)
  ) u_alu (
    .op_i     (op_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .shamt_i  (shamt_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    op_d         = op_q;
    x_d          = x_q;
    y_d          = y_q;
    shamt_d      = shamt_q;
    result_d     = result_q;
    zero_d       = zero_q;
    count_d      = count_q;
    req_ready_o  = '0;
    resp_valid_o = '0;

    unique case (state_q)
      StIdle: begin
        // Ready is withheld while reset is asserted so nothing looks accepted.
        if (reset_ni && (|req_valid_i)) begin
          req_ready_o[grant] = 1'b1;
          owner_d            = grant;
          rr_last_d          = grant;
          op_d               = grant ? req_op_i[OpW +: OpW]       : req_op_i[0 +: OpW];
          x_d                = grant ? req_x_i[Width +: Width]    : req_x_i[0 +: Width];
          y_d                = grant ? req_y_i[Width +: Width]    : req_y_i[0 +: Width];
          shamt_d            = grant ? req_shamt_i[ShW +: ShW]    : req_shamt_i[0 +: ShW];
          state_d            = StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = StResp;
      end
      StResp: begin
        resp_valid_o[owner_q] = 1'b1;
        if (resp_ready_i[owner_q]) begin
          count_d = count_q + CntW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      op_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      shamt_q   <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      shamt_q   <= shamt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      count_q   <= count_d;
    end
  end

  assign resp_result_o = result_q;
  assign resp_zero_o   = zero_q;
  assign busy_o        = (state_q != StIdle);
  assign op_count_o    = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses are queued at acceptance and
// checked when the arbiter presents them.
module tb_alu_share_arbiter;

  localparam int W    = 32;
  localparam int OW   = 4;
  localparam int SW   = 5;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*OW-1:0] req_op;
  logic [2*W-1:0]  req_x;
  logic [2*W-1:0]  req_y;
  logic [2*SW-1:0] req_shamt;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [W-1:0]    resp_result;
  logic            resp_zero;
  logic            busy;
  logic [CW-1:0]   op_count;

  typedef struct packed {
    logic [1:0]   vld;
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   exp_count = 0;
  int   exp_last  = 1;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .Width (W),
    .OpW   (OW),
    .ShW   (SW),
    .CntW  (CW)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_x_i       (req_x),
    .req_y_i       (req_y),
    .req_shamt_i   (req_shamt),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result),
    .resp_zero_o   (resp_zero),
    .busy_o        (busy),
    .op_count_o    (op_count)
  );

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic [4:0] sh);
    logic [W-1:0] fill;
    fill = x[W-1] ? ~(32'hffff_ffff >> sh) : 32'h0;
    case (op)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd3:    return ~x & ~y;
      4'd4:    return x << sh;
      4'd5:    return x >> sh;
      4'd6:    return x + ~y + 32'd1;
      4'd7:    return (x[W-1] != y[W-1]) ? {31'd0, x[W-1]} : {31'd0, (x < y)};
      4'd8:    return (x >> sh) | fill;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [4:0] sh);
    req_op[r*OW +: OW]    = op;
    req_x[r*W +: W]       = x;
    req_y[r*W +: W]       = y;
    req_shamt[r*SW +: SW] = sh;
    req_valid[r]          = 1'b1;
  endtask

  // Call just after a clock edge; returns after the accepting posedge (+1).
  task automatic accept_one(input bit keep, output int g);
    exp_t e;
    logic [W-1:0] r;
    g = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        if (&req_valid) chk("rr_grant", 64'(g), 64'(1 - exp_last));
        else            chk("single_grant", 64'(req_ready), 64'(req_valid));
        r = model(req_op[g*OW +: OW], req_x[g*W +: W], req_y[g*W +: W],
                  req_shamt[g*SW +: SW]);
        e.vld  = (g == 1) ? 2'b10 : 2'b01;
        e.res  = r;
        e.zero = (r == 32'h0);
        sb.push_back(e);
        exp_last = g;
        @(posedge clk);
        #1;
        if (!keep) req_valid[g] = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (g < 0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic collect(input int stall);
    exp_t e;
    int   lat;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      chk("resp_timeout", 64'd0, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency", 64'(lat), 64'd1);
    chk("resp_valid", 64'(resp_valid), 64'(e.vld));
    chk("resp_result", 64'(resp_result), 64'(e.res));
    chk("resp_zero", 64'(resp_zero), 64'(e.zero));
    for (int s = 0; s < stall; s++) begin
      resp_ready = ~e.vld;  // non-owner ready must be ignored
      @(negedge clk);
      chk("stall_valid", 64'(resp_valid), 64'(e.vld));
      chk("stall_result", 64'(resp_result), 64'(e.res));
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_count", 64'(op_count), 64'(exp_count % 16));
    end
    resp_ready = e.vld;
    @(posedge clk);
    #1;
    resp_ready = 2'b00;
    exp_count++;
    chk("op_count", 64'(op_count), 64'(exp_count % 16));
    chk("idle_after_resp", 64'(busy), 64'd0);
  endtask

  initial begin
    int g;
    int r;
    logic [3:0]  op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    reset_n    = 1'b0;
    req_valid  = 2'b00;
    req_op     = '0;
    req_x      = '0;
    req_y      = '0;
    req_shamt  = '0;
    resp_ready = 2'b00;

    // Reset with both requesters valid, then requester 0 must win first.
    set_req(0, 4'b0010, 32'd5, 32'd7, 5'd0);
    set_req(1, 4'b0001, 32'h0000_00f0, 32'h0000_000f, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    accept_one(1'b0, g);
    chk("first_grant", 64'(g), 64'd0);
    req_valid = 2'b00;
    collect(0);

    // Single ADD from requester 0.
    set_req(0, 4'b0010, 32'd5, 32'd7, 5'd0);
    accept_one(1'b0, g);
    collect(0);

    // Contention: both continuously valid, grants alternate.
    set_req(0, 4'b0110, 32'd10, 32'd3, 5'd0);
    set_req(1, 4'b0000, 32'h0000_ff00, 32'h0000_0ff0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      accept_one(1'b1, g);
      collect(0);
    end
    req_valid = 2'b00;

    // Backpressure with the other requester waiting.
    set_req(0, 4'b0010, 32'd5, 32'd7, 5'd0);
    accept_one(1'b0, g);
    set_req(1, 4'b0001, 32'd1, 32'd2, 5'd0);
    collect(5);
    req_valid = 2'b00;

    // Reset while the op is in EXEC: it is discarded.
    set_req(1, 4'b0001, 32'd1, 32'd2, 5'd0);
    accept_one(1'b0, g);
    chk("exec_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    void'(sb.pop_back());
    exp_count = 0;
    exp_last  = 1;
    @(negedge clk);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_op_count", 64'(op_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", 64'(resp_valid), 64'd0);
    end

    // 17 ops wrap the 4-bit counter to 1; mixed op codes including undefined ones.
    for (int i = 0; i < 17; i++) begin
      r  = i % 2;
      op = (i == 0) ? 4'b0110 : 4'($urandom_range(0, 15));
      x  = $urandom();
      y  = (i == 0) ? x : $urandom();
      set_req(r, op, x, y, 5'($urandom_range(0, 31)));
      accept_one(1'b0, g);
      collect((i % 3 == 0) ? 1 : 0);
    end
    chk("count_wrap", 64'(op_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
